// File: rtl/register_rx.sv
// Serial-in / parallel-out receiver for the LSB-first shift-out link, with a valid/ack holding register.
// Define REGISTER_RX_PARITY_EN to expect one trailing even-parity bit per frame.
module register_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx,
  input  logic             rx_en,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [CNT_W-1:0] counter,
  output logic             overrun,
  output logic             frame_err,
  output logic             parity_err
);

  // Handshake: data_valid rises when a frame completes and holds until an edge
  // where data_ack=1 and data_valid=1; a completing frame in that same edge keeps it set.

`ifdef REGISTER_RX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [FRAME-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               overrun_q, overrun_d;
  logic               frame_err_q, frame_err_d;
`ifdef REGISTER_RX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
`ifdef REGISTER_RX_PARITY_EN
    parity_d    = parity_q;
`endif

    if (valid_q && data_ack) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_en) begin
          shift_d[0] = rx;
          counter_d  = CNT_W'(1);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (rx_en) begin
          for (int i = 0; i < FRAME; i++) begin
            if (counter_q == CNT_W'(i)) shift_d[i] = rx;
          end
          if (counter_q == LAST) begin
            // Counter shows the full frame length for one cycle, then WAIT_LOW clears it.
            data_d    = shift_d[WIDTH-1:0];
            valid_d   = 1'b1;
            if (valid_q && !data_ack) overrun_d = 1'b1;
`ifdef REGISTER_RX_PARITY_EN
            parity_d  = ^shift_d;
`endif
            counter_d = CNT_W'(FRAME);
            state_d   = WAIT_LOW;
          end else begin
            counter_d = counter_q + CNT_W'(1);
          end
        end else begin
          frame_err_d = 1'b1;
          counter_d   = '0;
          state_d     = IDLE;
        end
      end
      WAIT_LOW: begin
        counter_d = '0;
        if (!rx_en) state_d = IDLE;
      end
      default: begin
        counter_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef REGISTER_RX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
`ifdef REGISTER_RX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign counter    = counter_q;
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;
`ifdef REGISTER_RX_PARITY_EN
  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_register_rx.sv
// Directed bench for register_rx (WIDTH=4); builds with or without REGISTER_RX_PARITY_EN.
module tb_register_rx;

  localparam int WIDTH = 4;
  localparam int CNT_W = 5;
`ifdef REGISTER_RX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk;
  logic             reset_n;
  logic             rx;
  logic             rx_en;
  logic             data_ack;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic [CNT_W-1:0] counter;
  logic             overrun;
  logic             frame_err;
  logic             parity_err;

  int tests_run = 0;
  int tests_failed = 0;
  logic [WIDTH-1:0] exp_q[$];

  register_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .rx_en      (rx_en),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .counter    (counter),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one full frame (bits[0] first), checking the counter after every edge.
  task automatic send_bits(input logic [7:0] bits, input logic ack_last, input string tag);
    for (int i = 0; i < FRAME; i++) begin
      rx_en    = 1'b1;
      rx       = bits[i];
      data_ack = (i == FRAME - 1) ? ack_last : 1'b0;
      tick();
      check({tag, "_cnt"}, 32'(counter), 32'(i + 1));
    end
    data_ack = 1'b0;
    exp_q.push_back(bits[WIDTH-1:0]);
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input logic ack_last, input string tag);
    logic [7:0] bits;
    bits = {3'b000, ^w, w};
    send_bits(bits, ack_last, tag);
  endtask

  task automatic check_frame(input string tag, input logic exp_ovr, input logic exp_par);
    logic [WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, 32'(data_out), 32'(e));
    end
    check({tag, "_valid"}, 32'(data_valid), 32'd1);
    check({tag, "_ovr"}, 32'(overrun), 32'(exp_ovr));
    check({tag, "_par"}, 32'(parity_err), 32'(exp_par));
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
  endtask

  task automatic gap(input logic ack);
    rx_en    = 1'b0;
    data_ack = ack;
    tick();
    data_ack = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    rx       = 1'b1;
    rx_en    = 1'b1;
    data_ack = 1'b0;

    // Reset held two cycles with rx_en high
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_valid", 32'(data_valid), 32'd0);
      check("rst_cnt", 32'(counter), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);
      check("rst_ferr", 32'(frame_err), 32'd0);
      check("rst_par", 32'(parity_err), 32'd0);
    end
    reset_n = 1'b1;
    gap(1'b0);

    // Basic frame 4'hB, then ack
    send(4'hB, 1'b0, "basic");
    check_frame("basic", 1'b0, 1'b0);
    gap(1'b1);
    check("basic_cnt_clr", 32'(counter), 32'd0);
    check("basic_ack", 32'(data_valid), 32'd0);

    // Overrun: second frame lands on an unacked word
    send(4'hB, 1'b0, "ovr1");
    check_frame("ovr1", 1'b0, 1'b0);
    gap(1'b0);
    check("ovr_hold", 32'(data_valid), 32'd1);
    send(4'hA, 1'b0, "ovr2");
    check_frame("ovr2", 1'b1, 1'b0);
    gap(1'b1);
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("ovr_ack", 32'(data_valid), 32'd0);
    reset_n = 1'b0;
    tick();
    check("ovr_rst", 32'(overrun), 32'd0);
    reset_n = 1'b1;

    // Same sequence but ack coincides with completion
    send(4'hB, 1'b0, "ack1");
    check_frame("ack1", 1'b0, 1'b0);
    gap(1'b0);
    send(4'hA, 1'b1, "ack2");
    check_frame("ack2", 1'b0, 1'b0);
    gap(1'b1);

    // Abort after two bits with a pending word
    send(4'h5, 1'b0, "pre_abort");
    check_frame("pre_abort", 1'b0, 1'b0);
    gap(1'b0);
    rx_en = 1'b1;
    rx = 1'b1;
    tick();
    check("abort_cnt1", 32'(counter), 32'd1);
    rx = 1'b0;
    tick();
    check("abort_cnt2", 32'(counter), 32'd2);
    rx_en = 1'b0;
    tick();
    check("abort_ferr", 32'(frame_err), 32'd1);
    check("abort_cnt0", 32'(counter), 32'd0);
    check("abort_data", 32'(data_out), 32'h5);
    check("abort_valid", 32'(data_valid), 32'd1);
    tick();
    check("abort_ferr_off", 32'(frame_err), 32'd0);
    gap(1'b1);
    check("abort_ack", 32'(data_valid), 32'd0);
    send(4'h3, 1'b0, "after_abort");
    check_frame("after_abort", 1'b0, 1'b0);

    // rx_en held high for 7 cycles: one frame, then WAIT_LOW ignores the rest
    gap(1'b1);
    send(4'h6, 1'b0, "b2b");
    check_frame("b2b", 1'b0, 1'b0);
    for (int k = FRAME; k < 7; k++) begin
      rx_en = 1'b1;
      rx = k[0];
      tick();
      check("b2b_wait_cnt", 32'(counter), 32'd0);
      check("b2b_wait_data", 32'(data_out), 32'h6);
      check("b2b_wait_valid", 32'(data_valid), 32'd1);
    end
    gap(1'b1);
    check("b2b_ack", 32'(data_valid), 32'd0);
    send(4'h9, 1'b0, "b2b_next");
    check_frame("b2b_next", 1'b0, 1'b0);

`ifdef REGISTER_RX_PARITY_EN
    // Good and bad even parity on 4'hB
    gap(1'b1);
    send_bits(8'b0001_1011, 1'b0, "par_ok");
    check_frame("par_ok", 1'b0, 1'b0);
    gap(1'b1);
    send_bits(8'b0000_1011, 1'b0, "par_bad");
    check_frame("par_bad", 1'b0, 1'b1);
`endif

    // Reset in the middle of a frame leaves nothing pending
    gap(1'b1);
    rx_en = 1'b1;
    rx = 1'b1;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_cnt", 32'(counter), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_par", 32'(parity_err), 32'd0);
    reset_n = 1'b1;
    rx_en = 1'b0;
    tick();
    check("midrst_after_valid", 32'(data_valid), 32'd0);
    check("midrst_after_ferr", 32'(frame_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
